// File: rtl/bus_rr_sched.sv
// rtl/bus_rr_sched.sv - round-robin packet bus scheduler
// Pops one packet per grant and routes it by header ID: unicast, broadcast or drop.
module bus_rr_sched #(
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic [3:0]                 grant_id,
  output logic                       busy,
  output logic [15:0]                drop_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT, DELIVER} state_t;

  localparam logic [drvrs-1:0] ONE = {{(drvrs-1){1'b0}}, 1'b1};

  state_t               state, state_n;
  logic [3:0]           last;
  logic [3:0]           win;
  logic                 win_vld;
  logic [pckg_sz-1:0]   head;
  logic [7:0]           dest;
  logic [drvrs-1:0]     route;
  logic                 drop;

  // Search order starts one past the last winner and wraps modulo drvrs.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= drvrs; k++) begin
      for (int i = 0; i < drvrs; i++) begin
        if (!win_vld && pndng[i] &&
            ((int'(last) + k == i) || (int'(last) + k == i + drvrs))) begin
          win_vld = 1'b1;
          win     = 4'(i);
        end
      end
    end
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (grant_id == 4'(i)) head = D_pop[i*pckg_sz +: pckg_sz];
    end
  end

  assign dest = head[pckg_sz-1 -: 8];

  // Self-addressed and out-of-range IDs leave route empty and count as drops.
  always_comb begin
    route = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (dest == broadcast) route[i] = (grant_id != 4'(i));
      else if (dest == 8'(i) && grant_id != 4'(i)) route[i] = 1'b1;
    end
    drop = (dest != broadcast) && (route == '0);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (win_vld) state_n = GRANT;
      GRANT:   state_n = DELIVER;
      DELIVER: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      grant_id <= '0;
      last     <= 4'(drvrs-1);
      busy     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      pop  <= '0;
      push <= '0;
      busy <= (state_n != IDLE);
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant_id <= win;
            last     <= win;
            pop      <= ONE << win;
          end
        end
        GRANT: begin
          // Head is captured on the same edge the FIFO advances.
          D_push <= head;
          push   <= route;
          if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_sched.sv
// tb/tb_bus_rr_sched.sv - randomized and directed bench for bus_rr_sched
// Driver FIFOs are queues; a transaction-level model predicts every output cycle.
module tb_bus_rr_sched;

  localparam int N = 4;
  localparam int W = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    pndng;
  logic [N*W-1:0]  D_pop;
  logic [N-1:0]    pop, push;
  logic [W-1:0]    D_push;
  logic [3:0]      grant_id;
  logic            busy;
  logic [15:0]     drop_cnt;

  bus_rr_sched #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .grant_id(grant_id),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  logic [W-1:0] fifo [N][$];
  logic [N-1:0] pop_seen = '0;
  int           n_checks = 0;
  int           n_err = 0;
  int           cyc = 0;
  bit           chk_en = 1'b0;

  logic [N-1:0] exp_pop, exp_push;
  logic [W-1:0] exp_dpush;
  logic [3:0]   exp_gid;
  logic         exp_busy;
  logic [15:0]  exp_drop;
  int           m_phase = 0;
  int           m_last = N-1;
  int           m_g = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      pndng[i] = (fifo[i].size() != 0);
      D_pop[i*W +: W] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (pop_seen[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
    refresh();
  endtask

  // Transaction model: a grant occupies three cycles (arbitrate, pop, deliver).
  always @(posedge clk) begin
    logic [W-1:0] pkt;
    int dest, w;
    if (reset) begin
      m_phase = 0; m_last = N-1;
      exp_pop = '0; exp_push = '0; exp_dpush = '0;
      exp_gid = '0; exp_busy = 1'b0; exp_drop = '0;
    end else begin
      exp_pop = '0; exp_push = '0;
      case (m_phase)
        0: begin
          exp_busy = 1'b0;
          if (pndng != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++)
              if (w < 0 && pndng[(m_last + k) % N]) w = (m_last + k) % N;
            m_g = w; m_last = w;
            exp_gid = 4'(w);
            exp_pop = N'(1) << w;
            exp_busy = 1'b1;
            m_phase = 1;
          end
        end
        1: begin
          pkt = (fifo[m_g].size() != 0) ? fifo[m_g][0] : '0;
          dest = int'(pkt[W-1 -: 8]);
          exp_dpush = pkt;
          if (dest == 255) exp_push = {N{1'b1}} & ~(N'(1) << m_g);
          else if (dest < N && dest != m_g) exp_push = N'(1) << dest;
          else if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
          exp_busy = 1'b1;
          m_phase = 2;
        end
        default: begin
          exp_busy = 1'b0;
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    pop_seen = pop;
    if (chk_en) begin
      chk("pop", pop, exp_pop);
      chk("push", push, exp_push);
      chk("D_push", D_push, exp_dpush);
      chk("grant_id", grant_id, exp_gid);
      chk("busy", busy, exp_busy);
      chk("drop_cnt", drop_cnt, exp_drop);
    end
  end

  task automatic send(input int i, input logic [W-1:0] pkt,
                      output logic [N-1:0] p, output logic [W-1:0] d);
    fifo[i].push_back(pkt);
    refresh();
    p = '0; d = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      if (push != '0) begin p = push; d = D_push; end
    end
  endtask

  logic [N-1:0] sp;
  logic [W-1:0] sd;
  int           gseq [8];
  int           gcyc [8];
  int           ngr;
  bit           got;

  initial begin
    reset = 1'b1;
    refresh();
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pop", pop, 4'b0);
    chk("rst_push", push, 4'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gid", grant_id, 4'd0);
    chk("rst_drop", drop_cnt, 16'd0);

    // Round robin with every FIFO pending.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 2; j++) fifo[i].push_back({8'((i + 1) % N), 8'(8'hA0 + i)});
    refresh();
    ngr = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      @(negedge clk);
      if (pop != '0 && ngr < 8) begin gseq[ngr] = int'(grant_id); gcyc[ngr] = cyc; ngr++; end
    end
    chk("rr_count", ngr, 8);
    chk("rr_g0", gseq[0], 0);
    chk("rr_g1", gseq[1], 1);
    chk("rr_g2", gseq[2], 2);
    chk("rr_g3", gseq[3], 3);
    chk("rr_g4", gseq[4], 0);
    for (int k = 1; k < 5; k++) chk("rr_gap", gcyc[k] - gcyc[k-1], 3);

    // Unicast latency.
    fifo[1].push_back(16'h02A5);
    refresh();
    tick();
    @(negedge clk);
    chk("uc_pop", pop, 4'b0010);
    chk("uc_gid", grant_id, 4'd1);
    chk("uc_busy1", busy, 1'b1);
    tick();
    @(negedge clk);
    chk("uc_push", push, 4'b0100);
    chk("uc_data", D_push, 16'h02A5);
    chk("uc_busy2", busy, 1'b1);
    chk("uc_nopop", pop, 4'b0);
    tick();
    @(negedge clk);
    chk("uc_idle", busy, 1'b0);

    send(2, 16'hFF3C, sp, sd);
    chk("bc_push", sp, 4'b1011);
    chk("bc_data", sd, 16'hFF3C);
    chk("bc_drop", drop_cnt, 16'd0);
    send(0, 16'h0711, sp, sd);
    chk("drop_range_push", sp, 4'b0);
    chk("drop_range_cnt", drop_cnt, 16'd1);
    send(3, 16'h0322, sp, sd);
    chk("drop_self_push", sp, 4'b0);
    chk("drop_self_cnt", drop_cnt, 16'd2);

    // Saturation: preload the counter near full instead of 65k packets.
    tick();
    force dut.drop_cnt = 16'hFFFD;
    release dut.drop_cnt;
    exp_drop = 16'hFFFD;
    for (int k = 0; k < 4; k++) send(0, 16'h0911, sp, sd);
    chk("sat_cnt", drop_cnt, 16'hFFFF);

    // Reset while a packet is in flight.
    fifo[1].push_back(16'h0214);
    refresh();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_pop", pop, 4'b0010);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_push", push, 4'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_gid", grant_id, 4'd0);
    chk("mid_drop", drop_cnt, 16'd0);
    chk("mid_popped", fifo[1].size(), 0);
    fifo[0].push_back(16'h0312);
    fifo[3].push_back(16'h0022);
    refresh();
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      tick();
      @(negedge clk);
      if (pop != '0) begin got = 1'b1; chk("mid_first_gid", grant_id, 4'd0); end
    end
    chk("mid_grant_seen", got, 1'b1);
    for (int c = 0; c < 10; c++) tick();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 2) == 0) begin
        int i, r;
        logic [7:0] d;
        i = $urandom_range(0, N-1);
        r = $urandom_range(0, 9);
        d = (r < 6) ? 8'(r) : (r < 8) ? 8'hFF : 8'($urandom);
        if (fifo[i].size() < 3) fifo[i].push_back({d, 8'($urandom)});
        refresh();
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 40; c++) tick();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
